// File: rtl/pipe_stage_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_hs                                                |
// | Description : Pipeline stage register with valid/ready handshake, flush,   |
// |               gated control field, optional skid entry and stall counter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_hs #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 136,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              acc;
  logic              rel;

  assign valid_o = (state != EMPTY);
  assign acc     = valid_i & ready_o;
  assign rel     = valid_o & ready_i;
  assign ctrl_o  = valid_o ? main_ctrl : '0;
  assign data_o  = main_data;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;

      // Ready depends on state flops only, breaking the ready_i -> ready_o path.
      assign ready_o   = (state != FULL);
      assign skid_load = ~flush_i & acc & ~rel & (state == BUSY);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          skid_ctrl <= '0;
          skid_data <= '0;
        end else if (skid_load) begin
          skid_ctrl <= ctrl_i;
          skid_data <= data_i;
        end
      end
    end else begin : g_single
      assign ready_o   = ~valid_o | ready_i;
      assign skid_ctrl = '0;
      assign skid_data = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state     <= BUSY;
            main_ctrl <= ctrl_i;
            main_data <= data_i;
          end
        end
        BUSY: begin
          if (acc && rel) begin
            main_ctrl <= ctrl_i;
            main_data <= data_i;
          end else if (acc) begin
            if (SKID != 0) state <= FULL;
          end else if (rel) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (rel) begin
            state     <= BUSY;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating; deliberately untouched by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (valid_o && !ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
